board_renderer: RTL
===================

BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths (line total 800).
REQ-003 SHALL have parameter V_VISIBLE / V_FRONT / V_SYNC / V_BACK, defaults 480 / 10 / 2 / 33 (frame total 525).
REQ-004 SHALL have parameter BOARD_X0 / BOARD_Y0, defaults 240 / 80, pixel origin of the board's top-left cell.
REQ-005 SHALL have parameter CELL_PX, default 16, cell edge length in pixels (power of two).
REQ-006 SHALL have port clock, input, 1, pixel clock (25 MHz); the single clock.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port cell_rd_en, output, 1, board read strobe.
REQ-009 SHALL have port cell_x, output, 4, board column 0..9.
REQ-010 SHALL have port cell_y, output, 5, board row 0..19.
REQ-011 SHALL have port cell_data, input, 3, tetrimino code returned exactly 1 cycle after cell_rd_en.
REQ-012 SHALL have port hsync / vsync, output, 1 each, active-low sync.
REQ-013 SHALL have port rgb, output, 8, pixel colour R3G3B2.
REQ-014 SHALL have port framenumber, output, 10, frame counter for the game logic.

Function
REQ-015 SHALL keep hcount 0..799 and vcount 0..524; hcount wraps to 0 with vcount +1; vcount wraps at 524 → 0.
REQ-016 SHALL pipeline 3 stages: S0 counters/region decode, S1 read issue, S2 data capture plus palette, with registered outputs; hsync, vsync and rgb SHALL appear 3 cycles after the counter state that generates them.
REQ-017 SHALL assert hsync low for hcount in [656,751] and vsync low for vcount in [490,491], both delayed per REQ-016.
REQ-018 SHALL treat the board region as BOARD_X0 ≤ h < BOARD_X0+10·CELL_PX and BOARD_Y0 ≤ v < BOARD_Y0+20·CELL_PX.
REQ-019 SHALL, inside the board region, pulse cell_rd_en in S1 with cell_x = (h−BOARD_X0)/CELL_PX and cell_y = (v−BOARD_Y0)/CELL_PX; elsewhere cell_rd_en=0 and cell_x/cell_y hold their last values.
REQ-020 SHALL map codes through the palette: 000 black 0x00, 111 cyan 0x1F, 100 orange 0xF4, 001 blue 0x03, 010 green 0x1C, 110 red 0xE0, 101 yellow 0xFC, 011 magenta 0xE3.
REQ-021 SHALL draw the first pixel row and column of each board cell as grid colour 0x49 when the cell code is 000; non-blank cells are filled solid.
REQ-022 SHALL draw a 4-pixel white (0xFF) border immediately outside the board region.
REQ-023 SHALL output rgb=0x00 outside the visible area and for all other non-board pixels.
REQ-024 SHALL increment framenumber (mod 1024, 1023→0) on the cycle vcount reaches 490, in step with the undelayed vsync assertion edge.
REQ-025 SHALL ignore cell_data in any cycle not following a cell_rd_en pulse.

Reset
REQ-026 SHALL, while reset is high, asynchronously force hcount=0, vcount=0, framenumber=0, cell_rd_en=0, cell_x=0, cell_y=0, rgb=0x00, hsync=1, vsync=1, and clear all pipeline valid/region flags.
REQ-027 SHALL, after reset is released mid-frame, restart at pixel (0,0), with no sync pulse or read strobe emitted from pre-reset pipeline contents.

Structure
REQ-028 SHALL place the tetrimino code constants, BLANK, the palette table and the default timing constants in the shared package petris_pkg, which the game logic also uses.
REQ-029 SHALL split the counters and sync decode into the sub-module vga_timing; region decode, read issue and palette stay in board_renderer.

Verification
REQ-030 After reset release, bench SHALL see hsync period 800 cycles, low pulse 96 cycles, and vsync period 420000 cycles, low pulse 1600 cycles.
REQ-031 With a board model holding 101 at (5,0): at h=320, v=80 bench SHALL see cell_rd_en=1, cell_x=5, cell_y=0, and rgb=0xFC 2 cycles later for pixels 321..335.
REQ-032 With an all-000 board: pixel (240,80) SHALL be 0x49, pixel (241,81) 0x00, pixel (236,100) 0xFF, and pixel (100,100) 0x00.
REQ-033 Over 1025 frames, framenumber SHALL step 0,1,…,1023,0.
REQ-034 With reset asserted at h=300, v=200 for 5 cycles: outputs SHALL match REQ-026 immediately, and the first hsync low SHALL occur 656+3 cycles after release.
REQ-035 With cell_data driven to 111 on non-read cycles: border and background pixels SHALL remain unaffected.

Source files
------------

// File: rtl/petris_pkg.sv
// Shared Petris definitions: tetrimino codes, palette and default VGA timing,
// used by both the renderer and the game logic.
package petris_pkg;

    localparam int CNT_W      = 10;
    localparam int FRAME_W    = 10;
    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    localparam int BORDER_PX  = 4;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam int BOARD_X0_DEF  = 240;
    localparam int BOARD_Y0_DEF  = 80;
    localparam int CELL_PX_DEF   = 16;

    typedef enum logic [2:0] {
        BLANK  = 3'b000,
        CODE_J = 3'b001,
        CODE_S = 3'b010,
        CODE_T = 3'b011,
        CODE_L = 3'b100,
        CODE_O = 3'b101,
        CODE_Z = 3'b110,
        CODE_I = 3'b111
    } tetrimino_e;

    localparam logic [7:0] GRID_RGB   = 8'h49;
    localparam logic [7:0] BORDER_RGB = 8'hFF;
    localparam logic [7:0] BACK_RGB   = 8'h00;

    // R3G3B2 colour indexed by tetrimino code
    localparam logic [7:0] PALETTE [8] = '{
        8'h00, 8'h03, 8'h1C, 8'hE3, 8'hF4, 8'hFC, 8'hE0, 8'h1F
    };

    function automatic logic [7:0] palette_lookup(input logic [2:0] code);
        return PALETTE[code];
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA pixel/line counters with undelayed sync decode and the
// frame counter that ticks when the vertical sync pulse begins.
module vga_timing
    import petris_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic               clock,
    input  logic               reset,
    output logic [CNT_W-1:0]   o_hcount,
    output logic [CNT_W-1:0]   o_vcount,
    output logic               o_hsync_n,
    output logic               o_vsync_n,
    output logic [FRAME_W-1:0] o_framenumber
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0]   r_hcount;
    logic [CNT_W-1:0]   r_vcount;
    logic [FRAME_W-1:0] r_frame;
    logic [CNT_W-1:0]   w_vnext;

    always_comb begin
        w_vnext = (r_vcount == V_LAST) ? '0 : r_vcount + CNT_W'(1);
    end

    // S0: counter state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_frame  <= '0;
        end else if (r_hcount == H_LAST) begin
            r_hcount <= '0;
            r_vcount <= w_vnext;
            if (w_vnext == VS_FIRST) begin
                r_frame <= r_frame + FRAME_W'(1);
            end
        end else begin
            r_hcount <= r_hcount + CNT_W'(1);
        end
    end

    assign o_hcount      = r_hcount;
    assign o_vcount      = r_vcount;
    assign o_hsync_n     = !((r_hcount >= HS_FIRST) && (r_hcount <= HS_LAST));
    assign o_vsync_n     = !((r_vcount >= VS_FIRST) && (r_vcount <= VS_LAST));
    assign o_framenumber = r_frame;

endmodule

// File: rtl/board_renderer.sv
// Petris playfield renderer: decodes the board region from the VGA counters,
// reads one cell per pixel and colours it through the shared palette.
module board_renderer
    import petris_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF,
    parameter int BOARD_X0  = BOARD_X0_DEF,
    parameter int BOARD_Y0  = BOARD_Y0_DEF,
    parameter int CELL_PX   = CELL_PX_DEF
) (
    input  logic       clock,
    input  logic       reset,
    output logic       cell_rd_en,
    output logic [3:0] cell_x,
    output logic [4:0] cell_y,
    input  logic [2:0] cell_data,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb,
    output logic [9:0] framenumber
);

    localparam int SHIFT = $clog2(CELL_PX);
    localparam int BW    = BOARD_COLS * CELL_PX;
    localparam int BH    = BOARD_ROWS * CELL_PX;

    localparam logic [CNT_W-1:0] HV_END    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] VV_END    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] BX_LO     = CNT_W'(BOARD_X0);
    localparam logic [CNT_W-1:0] BX_HI     = CNT_W'(BOARD_X0 + BW);
    localparam logic [CNT_W-1:0] BY_LO     = CNT_W'(BOARD_Y0);
    localparam logic [CNT_W-1:0] BY_HI     = CNT_W'(BOARD_Y0 + BH);
    localparam logic [CNT_W-1:0] FX_LO     = CNT_W'(BOARD_X0 - BORDER_PX);
    localparam logic [CNT_W-1:0] FX_HI     = CNT_W'(BOARD_X0 + BW + BORDER_PX);
    localparam logic [CNT_W-1:0] FY_LO     = CNT_W'(BOARD_Y0 - BORDER_PX);
    localparam logic [CNT_W-1:0] FY_HI     = CNT_W'(BOARD_Y0 + BH + BORDER_PX);
    localparam logic [CNT_W-1:0] CELL_MASK = CNT_W'(CELL_PX - 1);

    logic [CNT_W-1:0] w_hcount;
    logic [CNT_W-1:0] w_vcount;
    logic             w_hsync_n;
    logic             w_vsync_n;
    logic [CNT_W-1:0] w_dx;
    logic [CNT_W-1:0] w_dy;
    logic             w_in_vis;
    logic             w_in_board;
    logic             w_in_frame;
    logic             w_border;
    logic             w_grid;
    logic [7:0]       w_pix;

    logic       r_vld_p1;
    logic [3:0] r_cell_x_p1;
    logic [4:0] r_cell_y_p1;
    logic       r_grid_p1;
    logic       r_border_p1;
    logic       r_hs_p1;
    logic       r_vs_p1;
    logic       r_vld_p2;
    logic       r_grid_p2;
    logic       r_border_p2;
    logic       r_hs_p2;
    logic       r_vs_p2;
    logic [7:0] r_rgb;
    logic       r_hsync;
    logic       r_vsync;

    vga_timing #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clock        (clock),
        .reset        (reset),
        .o_hcount     (w_hcount),
        .o_vcount     (w_vcount),
        .o_hsync_n    (w_hsync_n),
        .o_vsync_n    (w_vsync_n),
        .o_framenumber(framenumber)
    );

    always_comb begin
        w_dx       = w_hcount - BX_LO;
        w_dy       = w_vcount - BY_LO;
        w_in_vis   = (w_hcount < HV_END) && (w_vcount < VV_END);
        w_in_board = w_in_vis && (w_hcount >= BX_LO) && (w_hcount < BX_HI)
                     && (w_vcount >= BY_LO) && (w_vcount < BY_HI);
        w_in_frame = (w_hcount >= FX_LO) && (w_hcount < FX_HI)
                     && (w_vcount >= FY_LO) && (w_vcount < FY_HI);
        w_border   = w_in_vis && w_in_frame && !w_in_board;
        w_grid     = ((w_dx & CELL_MASK) == '0) || ((w_dy & CELL_MASK) == '0);
    end

    // S1: read issue; cell address holds outside the board
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_p1    <= 1'b0;
            r_cell_x_p1 <= '0;
            r_cell_y_p1 <= '0;
            r_border_p1 <= 1'b0;
            r_hs_p1     <= 1'b1;
            r_vs_p1     <= 1'b1;
        end else begin
            r_vld_p1    <= w_in_board;
            r_border_p1 <= w_border;
            r_hs_p1     <= w_hsync_n;
            r_vs_p1     <= w_vsync_n;
            if (w_in_board) begin
                r_cell_x_p1 <= 4'(w_dx >> SHIFT);
                r_cell_y_p1 <= 5'(w_dy >> SHIFT);
            end
        end
    end

    // S2: cell_data arrives; sideband follows
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_p2    <= 1'b0;
            r_border_p2 <= 1'b0;
            r_hs_p2     <= 1'b1;
            r_vs_p2     <= 1'b1;
        end else begin
            r_vld_p2    <= r_vld_p1;
            r_border_p2 <= r_border_p1;
            r_hs_p2     <= r_hs_p1;
            r_vs_p2     <= r_vs_p1;
        end
    end

    always_ff @(posedge clock) begin
        r_grid_p1 <= w_grid;
        r_grid_p2 <= r_grid_p1;
    end

    // cell_data is only trusted in the cycle after a read strobe
    always_comb begin
        w_pix = BACK_RGB;
        if (r_vld_p2) begin
            if (cell_data == BLANK) begin
                w_pix = r_grid_p2 ? GRID_RGB : palette_lookup(BLANK);
            end else begin
                w_pix = palette_lookup(cell_data);
            end
        end else if (r_border_p2) begin
            w_pix = BORDER_RGB;
        end
    end

    // S3: registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rgb   <= BACK_RGB;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else begin
            r_rgb   <= w_pix;
            r_hsync <= r_hs_p2;
            r_vsync <= r_vs_p2;
        end
    end

    assign cell_rd_en = r_vld_p1;
    assign cell_x     = r_cell_x_p1;
    assign cell_y     = r_cell_y_p1;
    assign rgb        = r_rgb;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;

endmodule
